// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// Contents: fetch FSM state enum (S_ERR only with IFU_MISALIGN_CHK_EN),
// default reset PC, and the NOP word presented on a misaligned redirect.
package ifu_pkg;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
`ifdef IFU_MISALIGN_CHK_EN
        , S_ERR
`endif
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

endpackage

// File: rtl/ifu_obuf.sv
// ifu_obuf: single-entry valid/ready output buffer with flush.
// Ports: clk, rst_n (async, active-low); load/load_inst/load_pc write the
// entry; flush drops it; out_valid/out_ready/out_inst/out_pc face decode.
// load wins over flush so a redirect can replace the entry in one edge.
module ifu_obuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_inst  <= load_inst;
            out_pc    <= load_pc;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit; one outstanding fetch, single output entry.
// Ports: clk, rst_n (async, active-low); redirect_valid/redirect_pc from the
// branch unit; imem_req_* / imem_resp_* to instruction memory; inst_valid/
// inst_ready/inst/inst_pc to decode; misalign only with IFU_MISALIGN_CHK_EN,
// which also adds the S_ERR state for misaligned redirect targets.
import ifu_pkg::*;

module ifu #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, tgt, load_inst, load_pc;
    logic        pend, acc, out_pend, load;

    assign imem_req_valid = rst_n && state == S_REQ;
    assign imem_req_addr  = pc;
    assign acc            = imem_req_valid && imem_req_ready;
    assign tgt            = {redirect_pc[31:2], 2'b00};
    // A response is still owed after this edge; a redirect must then discard it.
    assign out_pend       = acc || (pend && !imem_resp_valid);

`ifdef IFU_MISALIGN_CHK_EN
    assign misalign = state == S_ERR;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= out_pend;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        load_inst = imem_resp_data;
        load_pc   = pc;
        case (state)
            S_REQ:  state_nxt = acc ? S_WAIT : S_REQ;
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_nxt = S_HOLD;
                    load      = 1'b1;
                    pc_nxt    = pc + 32'd4;
                end
            end
            S_DROP: state_nxt = imem_resp_valid ? S_REQ : S_DROP;
            S_HOLD: state_nxt = inst_ready ? S_REQ : S_HOLD;
`ifdef IFU_MISALIGN_CHK_EN
            S_ERR:  state_nxt = inst_ready ? (out_pend ? S_DROP : S_REQ) : S_ERR;
`endif
            default: state_nxt = S_REQ;
        endcase
        // Redirect overrides everything decided above for this edge.
        if (redirect_valid) begin
            pc_nxt    = tgt;
            load      = 1'b0;
            state_nxt = out_pend ? S_DROP : S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_nxt = S_ERR;
                load      = 1'b1;
                load_inst = NOP;
                load_pc   = redirect_pc;
            end
`endif
        end
    end

    ifu_obuf u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_inst (load_inst),
        .load_pc   (load_pc),
        .flush     (redirect_valid),
        .out_ready (inst_ready),
        .out_valid (inst_valid),
        .out_inst  (inst),
        .out_pc    (inst_pc)
    );

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu with a 1-cycle (optionally 2-cycle) memory model.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_CHK_EN
    logic        misalign;
`endif

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .misalign        (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mis;
        int          gap;
    } exp_t;

    exp_t        iq[$];
    exp_t        e;
    logic [31:0] rq[$];
    logic [31:0] ra;
    int checks = 0, errors = 0, hs_cnt = 0, cyc = 0, last_cyc = 0, mem_delay = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    task automatic push_i(input logic [31:0] pc, input logic [31:0] ins, input logic mis, input int gap);
        exp_t x;
        x.pc = pc; x.ins = ins; x.mis = mis; x.gap = gap;
        iq.push_back(x);
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout actual none required event", nm);
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_cnt < n && t < 200) begin @(negedge clk); #1; t++; end
        if (hs_cnt < n) timeout("wait_hs");
        @(posedge clk); #1;
    endtask

    task automatic wait_acc();
        int t = 0;
        bit ok = 0;
        while (!ok && t < 200) begin
            @(negedge clk); #1; t++;
            ok = imem_req_valid && imem_req_ready;
        end
        if (!ok) timeout("wait_acc");
        @(posedge clk); #1;
    endtask

    task automatic wait_iv();
        int t = 0;
        while (!inst_valid && t < 200) begin @(negedge clk); #1; t++; end
        if (!inst_valid) timeout("wait_iv");
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers each accepted request mem_delay cycles after the
    // cycle following acceptance.
    initial begin : mem
        logic        acc;
        logic [31:0] a, paddr;
        bit          pend;
        int          cnt;
        pend = 0; cnt = 0; paddr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc = imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            @(posedge clk); #1;
            imem_resp_valid = 1'b0;
            if (acc) begin pend = 1; paddr = a; cnt = mem_delay; end
            if (pend) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mdata(paddr);
                    pend = 0;
                end else cnt--;
            end
        end
    end

    // Monitor: requests and delivered instructions are popped and compared.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected actual %h required none", imem_req_addr);
            end else begin
                ra = rq.pop_front();
                chk("req_addr", imem_req_addr, ra);
            end
        end
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            hs_cnt++;
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL inst_unexpected actual pc %h required none", inst_pc);
            end else begin
                e = iq.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst", inst, e.ins);
`ifdef IFU_MISALIGN_CHK_EN
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
                if (e.gap != 0) chk("inst_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1);
    end

    initial begin
        int t;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
`ifdef IFU_MISALIGN_CHK_EN
        chk("rst_misalign", misalign, 0);
`endif
        // Sequential fetch at full rate.
        rq.push_back(32'h8000_0000); rq.push_back(32'h8000_0004);
        rq.push_back(32'h8000_0008); rq.push_back(32'h8000_000C);
        push_i(32'h8000_0000, mdata(32'h8000_0000), 0, 0);
        push_i(32'h8000_0004, mdata(32'h8000_0004), 0, 3);
        push_i(32'h8000_0008, mdata(32'h8000_0008), 0, 3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        // Decode stalls for 5 cycles in HOLD.
        wait_hs(3);
        inst_ready = 1'b0;
        wait_iv();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, mdata(32'h8000_000C));
            chk("hold_pc", inst_pc, 32'h8000_000C);
            chk("hold_no_req", imem_req_valid, 0);
        end
        @(posedge clk); #1;
        push_i(32'h8000_000C, mdata(32'h8000_000C), 0, 0);
        rq.push_back(32'h8000_0010);
        inst_ready = 1'b1;
        // Redirect in WAIT while the response arrives: word is discarded.
        wait_hs(4);
        wait_acc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        rq.push_back(32'h8000_0100);
        push_i(32'h8000_0100, mdata(32'h8000_0100), 0, 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_acc();
        @(negedge clk);
        mem_delay = 1;
        rq.push_back(32'h8000_0104);
        // Redirect in WAIT before the response -> DROP, then a second redirect in DROP.
        wait_hs(5);
        wait_acc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(posedge clk); #1;
        redirect_pc    = 32'h8000_0300;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        mem_delay = 0;
        rq.push_back(32'h8000_0300);
        push_i(32'h8000_0300, mdata(32'h8000_0300), 0, 0);
        rq.push_back(32'h8000_0304);
        // Redirect in HOLD with decode ready in the same cycle.
        wait_hs(6);
        inst_ready = 1'b0;
        wait_iv();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        inst_ready     = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        rq.push_back(32'h8000_0400);
        push_i(32'h8000_0400, mdata(32'h8000_0400), 0, 0);
        @(negedge clk);
        chk("redir_hold_valid", inst_valid, 0);
        // Redirect in REQ without, then with, a handshake; then address wrap.
        wait_hs(7);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        rq.push_back(32'h8000_0500);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        rq.push_back(32'hFFFF_FFFC);
        rq.push_back(32'h0000_0000);
        push_i(32'hFFFF_FFFC, mdata(32'hFFFF_FFFC), 0, 0);
        push_i(32'h0000_0000, mdata(32'h0000_0000), 0, 3);
`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned redirect while a fetch is being accepted.
        rq.push_back(32'h0000_0004);
        wait_hs(9);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        inst_ready     = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        push_i(32'h8000_0102, 32'h0000_0013, 1, 0);
        @(negedge clk);
        chk("err_misalign", misalign, 1);
        chk("err_valid", inst_valid, 1);
        chk("err_no_req", imem_req_valid, 0);
        @(posedge clk); #1;
        rq.push_back(32'h8000_0100);
        push_i(32'h8000_0100, mdata(32'h8000_0100), 0, 0);
        inst_ready = 1'b1;
`endif
        t = 0;
        while (rq.size() != 0 && t < 300) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        t = 0;
        while (iq.size() != 0 && t < 300) begin @(negedge clk); #1; t++; end
        chk("req_queue_drained", rq.size(), 0);
        chk("inst_queue_drained", iq.size(), 0);
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 redirect_valid  in  1  branch/jump taken from downstream branch unit.
REQ-005 redirect_pc  in  32  new fetch address.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  32  fetch address.
REQ-009 imem_resp_valid  in  1  instruction word returned; at most one outstanding; earliest one cycle after acceptance.
REQ-010 imem_resp_data  in  32  instruction word.
REQ-011 inst_valid  out  1  instruction available to decode.
REQ-012 inst_ready  in  1  decode consumes instruction.
REQ-013 inst  out  32  instruction word.
REQ-014 inst_pc  out  32  address of inst.
REQ-015 misalign  out  1  misaligned-target flag; present only with IFU_MISALIGN_CHK_EN.

Function
REQ-016 States: REQ, WAIT, DROP, HOLD (plus ERR with macro); pc register holds next fetch address.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-018 WAIT: on imem_resp_valid -> capture data and pc into output buffer; pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); -> HOLD.
REQ-019 HOLD: inst_valid=1; inst and inst_pc stable until inst_ready; on inst_ready -> REQ next cycle.
REQ-020 Redirect has priority over all same-cycle events; pc<=redirect_pc and output buffer invalidated in the same edge.
REQ-021 Redirect in REQ without handshake -> stay REQ; with handshake same cycle -> DROP.
REQ-022 Redirect in WAIT without response -> DROP; with response same cycle -> response discarded, -> REQ.
REQ-023 DROP: no request; the next response is discarded, -> REQ; further redirects update pc, state unchanged.
REQ-024 Redirect in HOLD: inst_valid deasserts next cycle, even if inst_ready was high that cycle, -> REQ.
REQ-025 Minimum latency: request accepted cycle N, response N+1, inst_valid N+2; throughput one instruction per 3 cycles when decode is always ready.
REQ-026 inst_valid never asserts for an instruction fetched before the most recent redirect.

Reset
REQ-027 While rst_n=0: state=REQ, pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, misalign=0, drop pending cleared.
REQ-028 First cycle after release: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-029 Reset mid-transaction abandons the outstanding response; the memory side is reset concurrently.

Configuration
REQ-030 Macro IFU_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 enters ERR. ERR issues no request and presents inst_valid=1, misalign=1, inst=32'h0000_0013, inst_pc=redirect_pc. On inst_ready it goes to REQ with pc={redirect_pc[31:2],2'b00}. An outstanding response at entry to ERR is dropped before fetch resumes.
REQ-031 Macro undefined: misalign port and ERR state absent; redirect_pc[1:0] forced to 0.

Structure
REQ-032 Package ifu_pkg: state enum, default RESET_PC constant, NOP constant 32'h0000_0013.
REQ-033 One sub-module ifu_obuf: single-entry valid/ready output buffer with flush input; FSM and pc remain in ifu.

Verification
REQ-034 Reset release, memory always ready, 1-cycle response, decode ready -> inst_pc sequence 8000_0000, 8000_0004, 8000_0008, each 3 cycles apart.
REQ-035 Redirect to 8000_0100 while in WAIT, response arrives next cycle -> that word is never presented; next request address is 8000_0100.
REQ-036 inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable; no imem_req_valid during those cycles.
REQ-037 Redirect in HOLD with inst_ready=1 same cycle -> no handshake counted; next request is redirect_pc.
REQ-038 pc=FFFF_FFFC fetched -> next request address 0000_0000.
REQ-039 With macro, redirect to 8000_0102 -> one output with misalign=1, inst=0000_0013, inst_pc=8000_0102; next request address 8000_0100.
